// File: rtl/adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM encoding and default width.
package adder_pkg;

  localparam int DEF_WIDTH = 8;

  // Encoding 2'd3 is unused and steers back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/fullAdder_Behavioral.sv
// One-bit full adder cell: the only arithmetic in the serial adder datapath.
module fullAdder_Behavioral (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  // Sum and carry of three input bits.
  always_comb begin
    {co, s} = {1'b0, a} + {1'b0, b} + {1'b0, ci};
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: one full adder cell reused over WIDTH cycles,
// LSB first, with valid/ready handshakes on both operand and result sides.
module serial_adder_ctrl
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           r_state, w_next;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_a_sr, r_b_sr, r_sum_sr;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry, r_cout;
  logic             w_s, w_c;
  logic [WIDTH-1:0] w_sum_next;
  logic             w_last;

  fullAdder_Behavioral u_fa (
    .a  (r_a_sr[0]),
    .b  (r_b_sr[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_c)
  );

  // New sum bit enters at the MSB; a 1-bit adder has nothing to shift.
  generate
    if (WIDTH == 1) begin : g_w1
      assign w_sum_next = w_s;
    end else begin : g_wn
      assign w_sum_next = {w_s, r_sum_sr[WIDTH-1:1]};
    end
  endgenerate

  assign w_last = (r_count == LAST);
  assign sum    = r_sum;
  assign cout   = r_cout;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Next state and state-decoded handshake/status outputs.
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (w_last) w_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Datapath: operand load, per-bit shift, and capture of the finished result
  // into output registers so sum/cout hold across IDLE and the next SHIFT.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count  <= '0;
      r_carry  <= 1'b0;
      r_a_sr   <= '0;
      r_b_sr   <= '0;
      r_sum_sr <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a_sr   <= a;
            r_b_sr   <= b;
            r_carry  <= cin;
            r_count  <= '0;
            r_sum_sr <= '0;
          end
        end
        ST_SHIFT: begin
          r_carry  <= w_c;
          r_a_sr   <= r_a_sr >> 1;
          r_b_sr   <= r_b_sr >> 1;
          r_sum_sr <= w_sum_next;
          r_count  <= r_count + 1'b1;
          if (w_last) begin
            r_sum  <= w_sum_next;
            r_cout <= w_c;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Directed and randomised checks of serial_adder_ctrl at WIDTH=8 and WIDTH=1.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, out_ready, cin;
  logic [7:0] a, b;
  logic       in_ready, out_valid, cout, busy;
  logic [7:0] sum;

  logic       in_valid1, cin1, a1, b1;
  logic       in_ready1, out_valid1, cout1, busy1, sum1;

  int n_asrt = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
  );

  serial_adder_ctrl #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
    .a(a1), .b(b1), .cin(cin1), .out_valid(out_valid1), .out_ready(out_ready),
    .sum(sum1), .cout(cout1), .busy(busy1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one operand pair, wait for out_valid, check latency and result.
  task automatic run_op(input string tag, input logic [7:0] ta, input logic [7:0] tb,
                        input logic tc, input logic [8:0] exp);
    int lat;
    a = ta; b = tb; cin = tc; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk({tag, "_in_ready_drop"}, {31'd0, in_ready}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd1);
    lat = 0;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
    chk({tag, "_latency"}, lat, 32'd8);
    chk({tag, "_result"}, {23'd0, cout, sum}, {23'd0, exp});
  endtask

  initial begin
    logic [8:0] exp;
    int         lat, cyc;
    bit         hs, done;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; a = '0; b = '0; cin = 1'b0;
    in_valid1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    step(); step();
    rst_n = 1'b1;

    // Reset state
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_sum_cout", {23'd0, cout, sum}, 32'd0);

    // Basic ops; out_ready high so DONE lasts one cycle
    run_op("zero", 8'h00, 8'h00, 1'b0, 9'h000);
    step();
    chk("zero_back_idle", {30'd0, in_ready, out_valid}, 32'd2);
    run_op("ff_01", 8'hFF, 8'h01, 1'b0, 9'h100);
    step();
    run_op("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 9'h1FF);
    step();
    run_op("mix", 8'hA5, 8'h5A, 1'b0, 9'h0FF);
    step();

    // Backpressure: hold result for 5 cycles while in_valid pulses are ignored
    out_ready = 1'b0;
    run_op("bp", 8'h12, 8'h34, 1'b1, 9'h047);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; a = 8'hEE; b = 8'hEE;
      step();
      chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_hold_result", {23'd0, cout, sum}, 32'h047);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk("bp_release", {29'd0, in_ready, out_valid, busy}, 32'd4);
    chk("bp_sum_held", {23'd0, cout, sum}, 32'h047);

    // Reset mid-SHIFT at count=4
    a = 8'h0F; b = 8'h01; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_state", {29'd0, in_ready, out_valid, busy}, 32'd4);
    chk("midrst_sum_cout", {23'd0, cout, sum}, 32'd0);
    lat = 0;
    while (lat < 12) begin
      step();
      lat++;
      if (out_valid) break;
    end
    chk("midrst_no_result", {31'd0, out_valid}, 32'd0);
    run_op("after_rst", 8'h0F, 8'h01, 1'b0, 9'h010);
    step();

    // WIDTH=1 instance
    a1 = 1'b1; b1 = 1'b1; cin1 = 1'b1; in_valid1 = 1'b1;
    step();
    in_valid1 = 1'b0;
    lat = 0;
    while (!out_valid1 && lat < 10) begin
      step();
      lat++;
    end
    chk("w1_latency", lat, 32'd1);
    chk("w1_result", {30'd0, cout1, sum1}, 32'd3);
    step();
    chk("w1_idle", {30'd0, in_ready1, out_valid1}, 32'd2);

    // Random back-to-back ops with random out_ready
    for (int k = 0; k < 1000; k++) begin
      a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
      exp = {1'b0, a} + {1'b0, b} + {8'd0, cin};
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      done = 1'b0; cyc = 0;
      while (!done && cyc < 100) begin
        out_ready = 1'($urandom_range(0, 1));
        hs = out_valid && out_ready;
        if (hs) chk("rnd_result", {23'd0, cout, sum}, {23'd0, exp});
        step();
        cyc++;
        if (hs) done = 1'b1;
      end
      chk("rnd_handshake", {31'd0, done}, 32'd1);
      chk("rnd_no_dup", {30'd0, in_ready, out_valid}, 32'd2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
